// File: rtl/mips_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mips_muldiv_sequencer
//  Purpose  : Multi-cycle MULT/MULTU/DIV/DIVU engine with the HI/LO registers.
//             One bit per cycle: shift-add multiplier or restoring divider,
//             followed by one sign-fix cycle. MTHI/MTLO write HI/LO directly
//             when idle.
//  Ports    : i_clk    rising-edge clock
//             i_reset  asynchronous active-high reset
//             i_start  request; i_op/i_a/i_b sampled when i_start && !o_busy
//             i_op     000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI,
//                      101 MTLO, others no-op
//             i_a      rs: multiplicand / dividend / MTHI-MTLO data
//             i_b      rt: multiplier / divisor
//             o_busy   operation in progress, starts ignored
//             o_done   one-cycle pulse when HI/LO hold a new mul/div result
//             o_hi     HI register
//             o_lo     LO register
//  Revision : 1.0  initial release
// ============================================================================
module mips_muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   localparam logic [2:0] c_OP_MULT  = 3'b000;
   localparam logic [2:0] c_OP_MULTU = 3'b001;
   localparam logic [2:0] c_OP_DIV   = 3'b010;
   localparam logic [2:0] c_OP_DIVU  = 3'b011;
   localparam logic [2:0] c_OP_MTHI  = 3'b100;
   localparam logic [2:0] c_OP_MTLO  = 3'b101;
   localparam logic [5:0] c_CNT_INIT = 6'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   state_t             r_state;
   logic               r_busy;
   logic               r_done;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic [5:0]         r_cnt;
   logic               r_is_div;
   logic               r_neg_a;     // dividend sign, gives the remainder its sign
   logic               r_neg_res;   // operand signs differ
   logic [WIDTH-1:0]   r_opnd;      // multiplicand or divisor magnitude
   logic [2*WIDTH-1:0] r_acc;       // {hi-half, multiplier} or {rem, quot}

   // Operand setup at acceptance: signed ops work on magnitudes.
   logic               w_signed;
   logic               w_neg_a;
   logic               w_neg_b;
   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;

   assign w_signed = ~i_op[0];
   assign w_neg_a  = w_signed & i_a[WIDTH-1];
   assign w_neg_b  = w_signed & i_b[WIDTH-1];
   assign w_mag_a  = w_neg_a ? -i_a : i_a;
   assign w_mag_b  = w_neg_b ? -i_b : i_b;

   // Multiply step: conditional add into the upper half with carry, then shift right.
   logic [WIDTH:0]     w_sum;
   logic [2*WIDTH-1:0] w_mul_next;

   assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
   assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

   // Divide step: the shifted partial remainder needs WIDTH+1 bits because the
   // remainder can reach divisor-1 before doubling.
   logic [WIDTH:0]     w_prem;
   logic               w_borrow;
   logic [WIDTH-1:0]   w_diff;
   logic [2*WIDTH-1:0] w_div_next;

   assign w_prem     = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_borrow   = (w_prem < {1'b0, r_opnd});
   assign w_diff     = w_prem[WIDTH-1:0] - r_opnd;
   assign w_div_next = {(w_borrow ? w_prem[WIDTH-1:0] : w_diff), r_acc[WIDTH-2:0], ~w_borrow};

   // Sign fix. Divide-by-zero needs no special case: every step keeps the
   // difference, so the quotient is all ones and the remainder is |a|; after
   // sign fix that is LO=-1 (a>=0) or 1 (a<0) and HI=a. The DIV overflow case
   // (0x80000000 / -1) likewise yields LO=0x80000000, HI=0 naturally.
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quot;
   logic [WIDTH-1:0]   w_rem;

   assign w_prod = r_neg_res ? -r_acc : r_acc;
   assign w_quot = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_rem  = r_neg_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state   <= ST_IDLE;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_cnt     <= '0;
         r_is_div  <= 1'b0;
         r_neg_a   <= 1'b0;
         r_neg_res <= 1'b0;
         r_opnd    <= '0;
         r_acc     <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  case (i_op)
                     c_OP_MULT, c_OP_MULTU, c_OP_DIV, c_OP_DIVU: begin
                        r_state   <= ST_CALC;
                        r_busy    <= 1'b1;
                        r_cnt     <= c_CNT_INIT;
                        r_is_div  <= i_op[1];
                        r_neg_a   <= w_neg_a;
                        r_neg_res <= w_neg_a ^ w_neg_b;
                        r_opnd    <= i_op[1] ? w_mag_b : w_mag_a;
                        r_acc     <= {{WIDTH{1'b0}}, (i_op[1] ? w_mag_a : w_mag_b)};
                     end
                     c_OP_MTHI: r_hi <= i_a;
                     c_OP_MTLO: r_lo <= i_a;
                     default: ;
                  endcase
               end
            end
            ST_CALC: begin
               r_acc <= r_is_div ? w_div_next : w_mul_next;
               if (r_cnt == 6'd0) begin
                  r_state <= ST_FIX;
               end else begin
                  r_cnt <= r_cnt - 6'd1;
               end
            end
            ST_FIX: begin
               if (r_is_div) begin
                  r_hi <= w_rem;
                  r_lo <= w_quot;
               end else begin
                  r_hi <= w_prod[2*WIDTH-1:WIDTH];
                  r_lo <= w_prod[WIDTH-1:0];
               end
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_done;
   assign o_hi   = r_hi;
   assign o_lo   = r_lo;

endmodule
`default_nettype wire
